tds_channel_packer: RTL
=======================

TDS_CHANNEL_PACKER -- requirements
Module: tds_channel_packer

Interface
REQ-001 SHALL have parameter CHANNEL_ID, default 0, meaning 4-bit channel number placed in the header.
REQ-002 SHALL have parameter MAX_WORDS, default 16, meaning the maximum number of 120-bit words per packet (range 1..1023).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning the number of idle cycles before a partial packet is flushed.
REQ-004 SHALL have port clk_readout, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: permits new packets to start.
REQ-007 SHALL have port tds_mode, input, 1 bit: 0 = pad, 1 = strip; copied into the header.
REQ-008 SHALL have port channel_data, input, 120 bits: channel FIFO dout.
REQ-009 SHALL have port channel_data_counter, input, 10 bits: channel FIFO occupancy.
REQ-010 SHALL have port channel_fifo_empty, input, 1 bit: channel FIFO empty flag.
REQ-011 SHALL have port channel_data_read, output, 1 bit: channel FIFO rd_en.
REQ-012 SHALL have port pkt_data, output, 32 bits: packet beat.
REQ-013 SHALL have port pkt_valid, output, 1 bit: beat valid.
REQ-014 SHALL have port pkt_last, output, 1 bit: marks the trailer beat.
REQ-015 SHALL have port pkt_ready, input, 1 bit: downstream accept.
REQ-016 SHALL have port busy, output, 1 bit: high while the FSM is not IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, HEADER, FETCH, LATCH, DATA, TRAILER.
REQ-018 IDLE->HEADER SHALL occur when enable=1 and either channel_data_counter>=MAX_WORDS or the timeout has expired with channel_fifo_empty=0.
- On this transition, latch N = min(channel_data_counter, MAX_WORDS).
REQ-019 The timeout counter SHALL:
- increment each cycle in IDLE while channel_fifo_empty=0;
- clear when the FIFO is empty or the FSM leaves IDLE;
- expire at TIMEOUT_CYCLES-1;
- saturate at that value.
REQ-020 The header beat SHALL be {16'hA5A5, CHANNEL_ID[3:0], tds_mode, 1'b0, N[9:0]}.
REQ-021 In HEADER, the FSM SHALL go to FETCH after the handshake pkt_valid&pkt_ready.
REQ-022 FETCH SHALL assert channel_data_read for exactly one cycle and then go to LATCH.
- The FIFO is standard-mode: dout is valid one cycle after rd_en.
REQ-023 LATCH SHALL capture channel_data into a 120-bit holding register and then go to DATA.
REQ-024 DATA SHALL emit four beats, MSB first:
- beat 0: {8'h00, w[119:96]};
- beat 1: w[95:64];
- beat 2: w[63:32];
- beat 3: w[31:0].
REQ-025 After beat 3 is accepted, DATA SHALL go to FETCH if words sent < N, otherwise to TRAILER.
REQ-026 The trailer beat SHALL be {16'hFEED, seq[15:0]} with pkt_last=1.
- On acceptance, seq increments (wrapping 16'hFFFF->0) and the FSM returns to IDLE.
REQ-027 pkt_data, pkt_valid and pkt_last SHALL be registered and held stable while pkt_valid=1 and pkt_ready=0.
- pkt_valid SHALL be 0 in IDLE, FETCH and LATCH.
REQ-028 Deasserting enable mid-packet SHALL NOT truncate the packet.
- The current packet completes; no new packet starts.
REQ-029 channel_data_read SHALL never assert while channel_fifo_empty=1.
- N is guaranteed readable because only this block reads the FIFO.
REQ-030 Packet length SHALL be 4N+2 beats.

Reset
REQ-031 On reset=1, asynchronously:
- FSM=IDLE;
- pkt_valid=0, pkt_last=0, pkt_data=0;
- channel_data_read=0, busy=0;
- seq=0, timeout counter=0;
- holding register=0.
REQ-032 Reset mid-packet SHALL abandon the packet with no trailer.
- Downstream detects the abandoned packet by a missing pkt_last.

Configuration
REQ-033 With TDS_PACKER_CRC_EN defined, the trailer SHALL be {crc16[15:0], seq[15:0]}.
- CRC-16-CCITT, polynomial 0x1021, init 0xFFFF.
- Covers header and all data beats, 32 bits per accepted beat, MSB first.
- Re-initialised when the FSM leaves IDLE.
REQ-034 Without TDS_PACKER_CRC_EN, the trailer SHALL be {16'hFEED, seq}, with no CRC logic.

Structure
REQ-035 A shared package tds_pkt_pkg SHALL hold:
- the FSM state enum;
- HDR_MARK=16'hA5A5;
- TRL_MARK=16'hFEED;
- CRC_POLY=16'h1021;
- CRC_INIT=16'hFFFF.
REQ-036 The single sub-module crc16_d32 SHALL be combinational next-CRC over a 32-bit word, instantiated only under TDS_PACKER_CRC_EN.

Verification
REQ-037 Full-packet scenario: MAX_WORDS=4, 4 words preloaded, pkt_ready=1.
- Header = A5A5_0_0_004 (CHANNEL_ID=0, tds_mode=0).
- 16 data beats follow, then trailer FEED0000 with pkt_last.
- 4 channel_data_read pulses total.
REQ-038 Timeout scenario: TIMEOUT_CYCLES=8, 1 word preloaded.
- After 8 idle cycles, a packet with N=1 is emitted (6 beats).
REQ-039 Backpressure scenario: pkt_ready toggled 1/0 every cycle.
- Every beat is held stable while stalled.
- Beat sequence is identical to the stall-free case.
REQ-040 Enable/reset scenario:
- enable dropped at data beat 5: the packet completes, then busy=0 and there are no further reads.
- reset asserted at data beat 5: pkt_valid=0 immediately and seq=0.
REQ-041 Sequence wrap scenario: seq forced to 16'hFFFF.
- The trailer carries FFFF.
- The next packet's trailer carries 0000.
REQ-042 CRC scenario: TDS_PACKER_CRC_EN defined, one all-zero word.
- Trailer upper 16 bits SHALL match the golden-model CRC of the 6 covered beats.

Source files
------------

// File: rtl/tds_pkt_pkg.sv
// Shared definitions for the TDS channel packer.
// Holds the packer FSM state enum, the header/trailer marker words, the
// CRC-16-CCITT constants and a helper that slices a 120-bit FIFO word into
// its four 32-bit packet beats.
package tds_pkt_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    FETCH   = 3'd2,
    LATCH   = 3'd3,
    DATA    = 3'd4,
    TRAILER = 3'd5
  } tds_state_e;

  localparam logic [15:0] HDR_MARK = 16'hA5A5;
  localparam logic [15:0] TRL_MARK = 16'hFEED;
  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  // Beat idx of a 120-bit word, most significant part first. Beat 0 carries
  // only 24 payload bits, so it is zero-extended to 32.
  function automatic logic [31:0] data_beat(input logic [119:0] w,
                                            input logic [1:0]   idx);
    logic [31:0] beat;
    case (idx)
      2'd0:    beat = {8'h00, w[119:96]};
      2'd1:    beat = w[95:64];
      2'd2:    beat = w[63:32];
      default: beat = w[31:0];
    endcase
    return beat;
  endfunction

endpackage

// File: rtl/tds_channel_packer_crc16_d32.sv
// crc16_d32: combinational next-state of a CRC-16-CCITT (poly 0x1021) over
// one 32-bit word, processed MSB first.
// Ports:
//   crc_i  [15:0] current CRC value
//   data_i [31:0] word folded into the CRC
//   crc_o  [15:0] CRC after all 32 bits of data_i
module crc16_d32
  import tds_pkt_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [31:0] data_i,
  output logic [15:0] crc_o
);

  logic [15:0] c;

  always_comb begin
    c = crc_i;
    for (int i = 31; i >= 0; i--) begin
      if (c[15] ^ data_i[i]) begin
        c = {c[14:0], 1'b0} ^ CRC_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/tds_channel_packer.sv
// tds_channel_packer: drains 120-bit words from a channel FIFO and frames
// them as a stream of 32-bit packet beats:
//   header  {A5A5, channel[3:0], tds_mode, 0, N[9:0]}
//   4 beats per word, MSB first (first beat zero-extended from 24 bits)
//   trailer {FEED, seq} -- or {crc16, seq} when TDS_PACKER_CRC_EN is defined
// A packet starts when N=MAX_WORDS words are waiting, or when a partial
// FIFO has sat idle for TIMEOUT_CYCLES cycles.
//
// Optional feature macro: TDS_PACKER_CRC_EN (CRC-16-CCITT trailer).
//
// Ports:
//   clk_readout          single clock, rising edge
//   reset                asynchronous active-high reset
//   enable               permits new packets to start (never truncates one)
//   tds_mode             0 = pad, 1 = strip; copied into the header
//   channel_data         FIFO dout (standard mode: valid the cycle after rd_en)
//   channel_data_counter FIFO occupancy
//   channel_fifo_empty   FIFO empty flag
//   channel_data_read    FIFO rd_en
//   pkt_data/valid/last  registered output beat, last marks the trailer
//   pkt_ready            downstream accept
//   busy                 FSM is not IDLE
//   fsm_state            current FSM state, for observation
//
// Handshake: a beat transfers on a rising edge where pkt_valid && pkt_ready.
// Once pkt_valid is raised, pkt_data/pkt_last hold still and pkt_valid stays
// high until that transfer; pkt_valid never depends on pkt_ready.
module tds_channel_packer
  import tds_pkt_pkg::*;
#(
  parameter int CHANNEL_ID     = 0,
  parameter int MAX_WORDS      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic         clk_readout,
  input  logic         reset,
  input  logic         enable,
  input  logic         tds_mode,
  input  logic [119:0] channel_data,
  input  logic [9:0]   channel_data_counter,
  input  logic         channel_fifo_empty,
  output logic         channel_data_read,
  output logic [31:0]  pkt_data,
  output logic         pkt_valid,
  output logic         pkt_last,
  input  logic         pkt_ready,
  output logic         busy,
  output tds_state_e   fsm_state
);

  localparam int          TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [9:0]  MAX_N    = 10'(MAX_WORDS);
  localparam logic [3:0]  CH_ID    = 4'(CHANNEL_ID);

  tds_state_e     state_q, state_d;
  logic [9:0]     n_q, n_d;          // words in the current packet
  logic [9:0]     words_q, words_d;  // words latched so far
  logic [1:0]     beat_q, beat_d;    // beat index within the held word
  logic [119:0]   hold_q, hold_d;
  logic [31:0]    data_q, data_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic [15:0]    seq_q, seq_d;
  logic           seq_inc;
  logic [TW-1:0]  tmo_q, tmo_d;

  logic           accept;
  logic           tmo_expired;
  logic           start;
  logic [9:0]     n_new;
  logic [31:0]    trailer;

  assign accept      = valid_q & pkt_ready;
  assign tmo_expired = (tmo_q == TMO_LAST);
  assign start       = enable &&
                       ((channel_data_counter >= MAX_N) ||
                        (tmo_expired && !channel_fifo_empty));
  assign n_new       = (channel_data_counter >= MAX_N) ? MAX_N : channel_data_counter;
  assign seq_d       = seq_q + 16'd1;

`ifdef TDS_PACKER_CRC_EN
  logic [15:0] crc_q, crc_d, crc_next;

  // crc_next folds in whatever beat is on the output; it is only committed
  // when that beat is accepted, so the last data beat is covered by the
  // trailer built on the same edge.
  crc16_d32 u_crc (
    .crc_i  (crc_q),
    .data_i (data_q),
    .crc_o  (crc_next)
  );

  assign trailer = {crc_next, seq_q};

  // Held at the initial value throughout IDLE, which re-initialises it for
  // every packet.
  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE) begin
      crc_d = CRC_INIT;
    end else if (accept && (state_q == HEADER || state_q == DATA)) begin
      crc_d = crc_next;
    end
  end

  always_ff @(posedge clk_readout or posedge reset) begin
    if (reset) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end
`else
  assign trailer = {TRL_MARK, seq_q};
`endif

  // Idle timeout: counts only while a partial FIFO sits in IDLE, saturating
  // at the expiry value until a packet starts or the FIFO empties.
  always_comb begin
    tmo_d = tmo_q;
    if (state_q != IDLE || channel_fifo_empty || start) begin
      tmo_d = '0;
    end else if (!tmo_expired) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Next state and next registered outputs. Output registers are loaded on
  // the same edge as the state change, so each beat appears together with
  // the state that owns it.
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    words_d = words_q;
    beat_d  = beat_q;
    hold_d  = hold_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    seq_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HEADER;
          n_d     = n_new;
          words_d = '0;
          data_d  = {HDR_MARK, CH_ID, tds_mode, 1'b0, n_new};
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      HEADER: begin
        if (accept) begin
          state_d = FETCH;
          valid_d = 1'b0;
        end
      end
      FETCH: begin
        state_d = LATCH;
      end
      LATCH: begin
        hold_d  = channel_data;
        words_d = words_q + 10'd1;
        beat_d  = 2'd0;
        data_d  = data_beat(channel_data, 2'd0);
        valid_d = 1'b1;
        state_d = DATA;
      end
      DATA: begin
        if (accept) begin
          if (beat_q == 2'd3) begin
            if (words_q < n_q) begin
              state_d = FETCH;
              valid_d = 1'b0;
            end else begin
              state_d = TRAILER;
              data_d  = trailer;
              last_d  = 1'b1;
            end
          end else begin
            beat_d = beat_q + 2'd1;
            data_d = data_beat(hold_q, beat_q + 2'd1);
          end
        end
      end
      TRAILER: begin
        if (accept) begin
          state_d = IDLE;
          valid_d = 1'b0;
          last_d  = 1'b0;
          seq_inc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_readout or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      n_q     <= '0;
      words_q <= '0;
      beat_q  <= '0;
      hold_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      words_q <= words_d;
      beat_q  <= beat_d;
      hold_q  <= hold_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      tmo_q   <= tmo_d;
    end
  end

  // The sequence number only moves on a completed trailer.
  always_ff @(posedge clk_readout or posedge reset) begin
    if (reset) begin
      seq_q <= '0;
    end else if (seq_inc) begin
      seq_q <= seq_d;
    end
  end

  // FETCH lasts one cycle, so the read strobe is a single pulse per word.
  assign channel_data_read = (state_q == FETCH);
  assign busy              = (state_q != IDLE);
  assign fsm_state         = state_q;
  assign pkt_data          = data_q;
  assign pkt_valid         = valid_q;
  assign pkt_last          = last_q;

endmodule
